// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the obstacle field: scroller FSM states, the gap
// LFSR polynomial and default seed, and the default screen/pipe geometry that
// the collision detector and renderer also rely on.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Scroller control states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FROZEN = 2'd2
   } state_t;

   // Galois feedback mask (right-shifting form) and default nonzero seed
   localparam logic [15:0] LFSR_MASK         = 16'hB400;
   localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

   // Default playfield geometry in pixels
   localparam int DEF_SCREEN_W     = 640;
   localparam int DEF_PIPE_W       = 52;
   localparam int DEF_PIPE_SPACING = 200;
   localparam int DEF_BIRD_X       = 150;
   localparam int DEF_GAP_MIN      = 80;
   localparam int DEF_GAP_MAX      = 320;

   // One step of the Galois LFSR: shift right, fold the mask in when the
   // bit falling off the bottom is set.
   function automatic logic [15:0] lfsrStep(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

endpackage

// File: rtl/gap_lfsr.sv
// -----------------------------------------------------------------------------
// gap_lfsr
// Free-running 16-bit Galois LFSR used as the pipe gap source. Besides the
// current state it pre-computes the folded gap centre for LOOKAHEAD
// consecutive states, so several pipes recycled on the same tick each get
// their own value (entry 0 from the current state, entry 1 from the next...).
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset (loads SEED)
//   en_i    in   advance the LFSR this cycle
//   gaps_o  out  LOOKAHEAD packed gap centres, entry k at [k*Y_W +: Y_W]
// -----------------------------------------------------------------------------
module gap_lfsr
   import pipe_pkg::*;
#(
   parameter logic [15:0] SEED      = LFSR_SEED_DEFAULT,
   parameter int          GAP_MIN   = DEF_GAP_MIN,
   parameter int          GAP_MAX   = DEF_GAP_MAX,
   parameter int          Y_W       = 10,
   parameter int          LOOKAHEAD = 4
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en_i,
   output logic [LOOKAHEAD*Y_W-1:0]   gaps_o
);

   localparam int RANGE = GAP_MAX - GAP_MIN;
   localparam int R_W   = $clog2(RANGE + 1);

   logic [15:0] lfsr_q;
   logic [15:0] stateChain;
   logic [31:0] r;

   // The LFSR runs independently of the game state; only reset reloads it,
   // so restarts still produce a fresh gap sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else if (en_i) begin
         lfsr_q <= lfsrStep(lfsr_q);
      end
   end

   // Fold the low R_W bits into [0, RANGE]: values above RANGE wrap back to
   // the bottom of the range instead of being clipped, then offset by GAP_MIN.
   always_comb begin
      stateChain = lfsr_q;
      r          = '0;
      gaps_o     = '0;
      for (int k = 0; k < LOOKAHEAD; k++) begin
         r = 32'(stateChain[R_W-1:0]);
         if (r > 32'(RANGE)) begin
            r = r - 32'(RANGE) - 32'd1;
         end
         gaps_o[k*Y_W +: Y_W] = Y_W'(r + 32'(GAP_MIN));
         stateChain = lfsrStep(stateChain);
      end
   end

endmodule

// File: rtl/pipe_scroller.sv
// -----------------------------------------------------------------------------
// pipe_scroller
// Parametrised obstacle generator and scroller. Keeps NUM_PIPES pipe right
// edges and gap centres in packed vectors, moves them left by `speed` px on
// each game tick while running, recycles pipes that leave the screen to the
// back of the train with a pseudo-random gap, and reports bird passes.
// Optional build macro: PIPE_SCROLLER_SPEED_RAMP_EN -- when defined, speed
// steps up by one each time the score crosses a multiple of SPEED_STEP,
// capped at SPEED_MAX; otherwise speed is the constant SPEED_INIT.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   tick         in   one-cycle game-step strobe
//   run          in   start/continue scrolling (level)
//   freeze       in   collision, stop scrolling (level)
//   restart      in   one-cycle pulse, reinitialise the field
//   pipe_x       out  packed pipe right edges, pipe i at [i*X_W +: X_W]
//   pipe_y       out  packed gap centres, pipe i at [i*Y_W +: Y_W]
//   score_pulse  out  one-cycle pulse when a pipe is passed
//   score_count  out  saturating pass count
//   speed        out  current px per tick
//   scrolling    out  high while in RUN
// -----------------------------------------------------------------------------
module pipe_scroller
   import pipe_pkg::*;
#(
   parameter int          NUM_PIPES    = 4,
   parameter int          X_W          = 11,
   parameter int          Y_W          = 10,
   parameter int          SCREEN_W     = DEF_SCREEN_W,
   parameter int          PIPE_W       = DEF_PIPE_W,
   parameter int          PIPE_SPACING = DEF_PIPE_SPACING,
   parameter int          BIRD_X       = DEF_BIRD_X,
   parameter int          GAP_MIN      = DEF_GAP_MIN,
   parameter int          GAP_MAX      = DEF_GAP_MAX,
   parameter int          SPEED_INIT   = 1,
   parameter int          SPEED_MAX    = 4,
   parameter int          SPEED_STEP   = 8,
   parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic                       run,
   input  logic                       freeze,
   input  logic                       restart,
   output logic [NUM_PIPES*X_W-1:0]   pipe_x,
   output logic [NUM_PIPES*Y_W-1:0]   pipe_y,
   output logic                       score_pulse,
   output logic [15:0]                score_count,
   output logic [2:0]                 speed,
   output logic                       scrolling
);

   localparam int               RESET_Y = (GAP_MIN + GAP_MAX) / 2;
   localparam int               PC_W    = $clog2(NUM_PIPES + 1);
   localparam logic [X_W:0]     WRAP    = (X_W+1)'(NUM_PIPES * PIPE_SPACING);
   localparam logic [X_W:0]     BIRD    = (X_W+1)'(BIRD_X);

   // Starting layout: pipe 0 just off the right edge, the rest spaced behind it
   function automatic logic [NUM_PIPES*X_W-1:0] initPipeX();
      logic [NUM_PIPES*X_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         v[i*X_W +: X_W] = X_W'(SCREEN_W + PIPE_W + i*PIPE_SPACING);
      end
      return v;
   endfunction

   localparam logic [NUM_PIPES*X_W-1:0] INIT_X = initPipeX();
   localparam logic [NUM_PIPES*Y_W-1:0] INIT_Y = {NUM_PIPES{Y_W'(RESET_Y)}};

   // Refuse to build a configuration whose recycled positions overflow X_W,
   // or whose speed could skip a whole pipe in one tick.
   if (SCREEN_W + PIPE_W + NUM_PIPES*PIPE_SPACING >= (1 << X_W)) begin : g_xWidthCheck
      $error("pipe_scroller: X_W too narrow for the pipe train");
   end
   if (SPEED_MAX >= PIPE_SPACING || SPEED_MAX > 7 || SPEED_INIT > SPEED_MAX) begin : g_speedCheck
      $error("pipe_scroller: speed range invalid");
   end
   if (SPEED_STEP < 1) begin : g_stepCheck
      $error("pipe_scroller: SPEED_STEP must be positive");
   end

   state_t                    state_q;
   logic [NUM_PIPES*X_W-1:0]  pipeX_q;
   logic [NUM_PIPES*Y_W-1:0]  pipeY_q;
   logic                      scorePulse_q;
   logic [15:0]               scoreCount_q;
   logic                      scrolling_q;

   logic [NUM_PIPES*Y_W-1:0]  gaps;
   logic [NUM_PIPES*X_W-1:0]  pipeX_d;
   logic [NUM_PIPES*Y_W-1:0]  pipeY_d;
   logic [PC_W-1:0]           passCount;
   logic [X_W:0]              xOld;
   logic [X_W:0]              xNew;
   logic [X_W:0]              spd;
   logic [16:0]               scoreSum;
   logic [15:0]               scoreCount_d;
   logic [2:0]                speedCur;
   int                        recIdx;

   gap_lfsr #(
      .SEED      (LFSR_SEED),
      .GAP_MIN   (GAP_MIN),
      .GAP_MAX   (GAP_MAX),
      .Y_W       (Y_W),
      .LOOKAHEAD (NUM_PIPES)
   ) u_gapLfsr (
      .clk    (clk),
      .rst    (rst),
      .en_i   (1'b1),
      .gaps_o (gaps)
   );

`ifdef PIPE_SCROLLER_SPEED_RAMP_EN
   logic [2:0] speed_q;
   logic       rampPend_q;
   logic       moveNow;
   logic       crossing;

   assign moveNow  = (state_q == RUN) && tick && !freeze && !restart;
   assign crossing = (scoreCount_d / 16'(SPEED_STEP)) != (scoreCount_q / 16'(SPEED_STEP));

   // A tick that pushes the score across a SPEED_STEP boundary arms a
   // one-cycle request; the speed bump lands the cycle after the score
   // update, so the faster speed first moves pipes on the following tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         speed_q    <= 3'(SPEED_INIT);
         rampPend_q <= 1'b0;
      end else if (restart) begin
         speed_q    <= 3'(SPEED_INIT);
         rampPend_q <= 1'b0;
      end else begin
         rampPend_q <= moveNow && crossing;
         if (rampPend_q && (speed_q < 3'(SPEED_MAX))) begin
            speed_q <= speed_q + 3'd1;
         end
      end
   end

   assign speedCur = speed_q;
`else
   assign speedCur = 3'(SPEED_INIT);
`endif

   assign spd = (X_W+1)'(speedCur);

   // Candidate positions for a movement step. A pipe at or left of `speed`
   // would go negative, so it jumps back a full train length instead and
   // takes the next unused gap from the LFSR lookahead (lowest pipe first).
   // Only non-recycling pipes can produce a pass.
   always_comb begin
      pipeX_d   = pipeX_q;
      pipeY_d   = pipeY_q;
      passCount = '0;
      recIdx    = 0;
      xOld      = '0;
      xNew      = '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         xOld = {1'b0, pipeX_q[i*X_W +: X_W]};
         if (xOld <= spd) begin
            xNew = xOld + WRAP - spd;
            pipeY_d[i*Y_W +: Y_W] = gaps[recIdx*Y_W +: Y_W];
            recIdx = recIdx + 1;
         end else begin
            xNew = xOld - spd;
            if (xOld >= BIRD && xNew < BIRD) begin
               passCount = passCount + 1'b1;
            end
         end
         pipeX_d[i*X_W +: X_W] = xNew[X_W-1:0];
      end
   end

   // Score after this tick's passes, pinned at the top of the 16-bit range
   always_comb begin
      scoreSum     = {1'b0, scoreCount_q} + 17'(passCount);
      scoreCount_d = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
   end

   // Control FSM with all game outputs registered. Restart beats every other
   // input, including a coincident tick or freeze. A freeze arriving with a
   // tick stops the field without applying that tick's movement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pipeX_q      <= INIT_X;
         pipeY_q      <= INIT_Y;
         scorePulse_q <= 1'b0;
         scoreCount_q <= '0;
         scrolling_q  <= 1'b0;
      end else if (restart) begin
         state_q      <= IDLE;
         pipeX_q      <= INIT_X;
         pipeY_q      <= INIT_Y;
         scorePulse_q <= 1'b0;
         scoreCount_q <= '0;
         scrolling_q  <= 1'b0;
      end else begin
         scorePulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (run && !freeze) begin
                  state_q     <= RUN;
                  scrolling_q <= 1'b1;
               end
            end
            RUN: begin
               if (freeze) begin
                  state_q     <= FROZEN;
                  scrolling_q <= 1'b0;
               end else if (tick) begin
                  pipeX_q      <= pipeX_d;
                  pipeY_q      <= pipeY_d;
                  scoreCount_q <= scoreCount_d;
                  scorePulse_q <= (passCount != '0);
               end
            end
            FROZEN: begin
               state_q <= FROZEN;
            end
            default: begin
               state_q     <= IDLE;
               scrolling_q <= 1'b0;
            end
         endcase
      end
   end

   assign pipe_x      = pipeX_q;
   assign pipe_y      = pipeY_q;
   assign score_pulse = scorePulse_q;
   assign score_count = scoreCount_q;
   assign speed       = speedCur;
   assign scrolling   = scrolling_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// -----------------------------------------------------------------------------
// tb_pipe_scroller
// Self-checking bench for pipe_scroller: a behavioural model of the pipe
// field (integer positions, explicit game mode) runs alongside the DUT and is
// compared every cycle, with a vector table for the control transitions and
// hand-written sequences for scoring, recycling, freeze, restart and ramp.
// -----------------------------------------------------------------------------
module tb_pipe_scroller;

   localparam int NP = 4;
   localparam int XW = 11;
   localparam int YW = 10;

`ifdef PIPE_SCROLLER_SPEED_RAMP_EN
   localparam int SPD_AFTER_8  = 2;
   localparam int SPD_AT_32    = 4;
`else
   localparam int SPD_AFTER_8  = 1;
   localparam int SPD_AT_32    = 1;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              tick;
   logic              run;
   logic              freeze;
   logic              restart;
   logic [NP*XW-1:0]  pipe_x;
   logic [NP*YW-1:0]  pipe_y;
   logic              score_pulse;
   logic [15:0]       score_count;
   logic [2:0]        speed;
   logic              scrolling;

   int testsRun    = 0;
   int testsFailed = 0;

   // Model state: mode 0 = idle, 1 = running, 2 = frozen
   int          mX[NP];
   int          mY[NP];
   int          mScore;
   int          mSpeed;
   int          mMode;
   int          mRampPend;
   int          mPulse;
   logic [15:0] mLfsr;

   typedef struct {
      logic run;
      logic freeze;
      logic tick;
      logic restart;
      logic expScroll;
      int   expX0;
      logic expPulse;
   } vec_t;

   vec_t vecs[12];

   pipe_scroller dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .run         (run),
      .freeze      (freeze),
      .restart     (restart),
      .pipe_x      (pipe_x),
      .pipe_y      (pipe_y),
      .score_pulse (score_pulse),
      .score_count (score_count),
      .speed       (speed),
      .scrolling   (scrolling)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsrNext(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   // Low byte folded into 0..240, then offset to the 80..320 band
   function automatic int gapOf(input logic [15:0] s);
      int r;
      r = int'(s[7:0]);
      if (r > 240) r = r - 241;
      return 80 + r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic modelLoadField();
      for (int i = 0; i < NP; i++) begin
         mX[i] = 640 + 52 + i*200;
         mY[i] = 200;
      end
      mScore    = 0;
      mSpeed    = 1;
      mMode     = 0;
      mRampPend = 0;
      mPulse    = 0;
   endtask

   // One clock of game behaviour, given the inputs present at that edge
   task automatic modelStep(input logic r, input logic f, input logic t, input logic rs);
      int          spdNow;
      int          passes;
      int          oldX;
      int          oldScore;
      int          crossNew;
      logic [15:0] s;
      mPulse   = 0;
      crossNew = 0;
      spdNow   = mSpeed;
      if (rs) begin
         modelLoadField();
      end else begin
         if (mMode == 0) begin
            if (r && !f) mMode = 1;
         end else if (mMode == 1) begin
            if (f) begin
               mMode = 2;
            end else if (t) begin
               s      = mLfsr;
               passes = 0;
               for (int i = 0; i < NP; i++) begin
                  if (mX[i] <= spdNow) begin
                     mX[i] = mX[i] + NP*200 - spdNow;
                     mY[i] = gapOf(s);
                     s     = lfsrNext(s);
                  end else begin
                     oldX  = mX[i];
                     mX[i] = mX[i] - spdNow;
                     if (oldX >= 150 && mX[i] < 150) passes++;
                  end
               end
               if (passes > 0) begin
                  oldScore = mScore;
                  mScore   = (mScore + passes > 65535) ? 65535 : mScore + passes;
                  mPulse   = 1;
                  crossNew = ((mScore / 8) != (oldScore / 8)) ? 1 : 0;
               end
            end
         end
`ifdef PIPE_SCROLLER_SPEED_RAMP_EN
         if (mRampPend != 0 && mSpeed < 4) mSpeed = mSpeed + 1;
`endif
         mRampPend = crossNew;
      end
      mLfsr = lfsrNext(mLfsr);
   endtask

   task automatic checkOutput();
      logic [NP*XW-1:0] ex;
      logic [NP*YW-1:0] ey;
      for (int i = 0; i < NP; i++) begin
         ex[i*XW +: XW] = XW'(mX[i]);
         ey[i*YW +: YW] = YW'(mY[i]);
      end
      check("model_pipe_x", pipe_x, ex);
      check("model_pipe_y", pipe_y, ey);
      check("model_score_pulse", score_pulse, mPulse[0]);
      check("model_score_count", score_count, mScore);
      check("model_speed", speed, mSpeed);
      check("model_scrolling", scrolling, (mMode == 1));
   endtask

   // Drive one cycle of inputs, advance the model, sample 1 unit after the edge
   task automatic applyStimulus(input logic r, input logic f, input logic t, input logic rs);
      run     = r;
      freeze  = f;
      tick    = t;
      restart = rs;
      modelStep(r, f, t, rs);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      logic [NP*XW-1:0] resetX;
      int               after32;
      int               checkNext;
      int               done;

      vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 692, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 692, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 692, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 691, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 690, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 690, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 690, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 690, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 692, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 692, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 691, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 692, 1'b0};

      // Reset
      rst     = 1'b1;
      tick    = 1'b0;
      run     = 1'b0;
      freeze  = 1'b0;
      restart = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      resetX = {11'd1292, 11'd1092, 11'd892, 11'd692};
      check("reset_pipe_x", pipe_x, resetX);
      for (int i = 0; i < NP; i++) check("reset_pipe_y", pipe_y[i*YW +: YW], 200);
      check("reset_score", score_count, 0);
      check("reset_pulse", score_pulse, 0);
      check("reset_speed", speed, 1);
      check("reset_scrolling", scrolling, 0);
      rst   = 1'b0;
      mLfsr = 16'hACE1;
      modelLoadField();

      // Control transitions from the vector table
      for (int v = 0; v < 12; v++) begin
         applyStimulus(vecs[v].run, vecs[v].freeze, vecs[v].tick, vecs[v].restart);
         check("vec_scrolling", scrolling, vecs[v].expScroll);
         check("vec_x0", pipe_x[XW-1:0], vecs[v].expX0);
         check("vec_pulse", score_pulse, vecs[v].expPulse);
      end

      // Scroll and score, ticks on alternate cycles, then on to the recycle
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int t = 1; t <= 692; t++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
         if (t == 542) begin
            check("t542_x0", pipe_x[XW-1:0], 150);
            check("t542_no_pulse", score_pulse, 0);
         end
         if (t == 543) begin
            check("t543_x0", pipe_x[XW-1:0], 149);
            check("t543_pulse", score_pulse, 1);
            check("t543_score", score_count, 1);
         end
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         if (t == 543) check("t543_pulse_one_cycle", score_pulse, 0);
      end
      check("t692_x0_recycled", pipe_x[XW-1:0], 800);
      check("t692_y0_low", (pipe_y[YW-1:0] >= 10'd80), 1);
      check("t692_y0_high", (pipe_y[YW-1:0] <= 10'd320), 1);
      check("t692_x1", pipe_x[XW +: XW], 200);
      check("t692_x3", pipe_x[3*XW +: XW], 600);

      // Freeze coincident with a tick, then ignored ticks, then restart
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      check("freeze_x0", pipe_x[XW-1:0], 800);
      check("freeze_scrolling", scrolling, 0);
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      check("frozen_x3", pipe_x[3*XW +: XW], 600);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      check("restart_pipe_x", pipe_x, resetX);
      check("restart_score", score_count, 0);
      check("restart_scrolling", scrolling, 0);

      // Restart colliding with the tick that would have scored
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      for (int t = 1; t <= 542; t++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      check("prio_pulse", score_pulse, 0);
      check("prio_pipe_x", pipe_x, resetX);
      check("prio_score", score_count, 0);

      // Speed ramp up to score 32 with a tick every cycle
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkNext = 0;
      after32   = 0;
      done      = 0;
      for (int c = 0; c < 9000 && done == 0; c++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
         if (checkNext != 0) begin
            check("ramp_speed_after_8", speed, SPD_AFTER_8);
            checkNext = 0;
         end
         if (score_pulse && score_count == 16'd8) begin
            check("ramp_speed_at_8th_pulse", speed, 1);
            checkNext = 1;
         end
         if (score_count >= 16'd32) after32++;
         if (after32 >= 3) done = 1;
      end
      if (done == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL ramp_budget: got score %0d, expected at least 32", score_count);
      end
      check("ramp_speed_at_32", speed, SPD_AT_32);

      // Randomized play against the model
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 3000; c++) begin
         applyStimulus(($urandom_range(0, 99) < 90),
                       ($urandom_range(0, 299) == 0),
                       ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 499) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
